// File: rtl/wb_arbiter_pkg.sv
// Shared constants for the writeback arbiter slice: requester count and
// register-file sizing used by the arbiter and its scoreboard.
package wb_arbiter_pkg;

   localparam int numRequesters = 2;
   localparam int defaultAddrWidth = 5;

   // Number of architectural registers addressed by an aw-bit register index.
   function automatic int regCount(input int aw);
      return 1 << aw;
   endfunction

endpackage

// File: rtl/wb_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: grants a lone requester at once and alternates
// between requesters when both contend, remembering who won the last transfer.
module rr_arb2
   import wb_arbiter_pkg::*;
(
   input  logic clock,
   input  logic reset,
   input  logic valid0,
   input  logic valid1,
   output logic grant0,
   output logic grant1
);

   logic                     lastGrant;
   logic [numRequesters-1:0] grant;

   // Contention goes to whichever requester did not win the previous transfer;
   // lastGrant high means requester 1 won last, so requester 0 is favoured.
   always_comb begin
      grant = '0;
      if (valid0 && valid1) begin
         if (lastGrant) begin
            grant[0] = 1'b1;
         end else begin
            grant[1] = 1'b1;
         end
      end else begin
         grant[0] = valid0;
         grant[1] = valid1;
      end
   end

   assign grant0 = grant[0];
   assign grant1 = grant[1];

   // A grant always coincides with a transfer, so the winner is recorded here.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         lastGrant <= 1'b1;
      end else if (grant[0]) begin
         lastGrant <= 1'b0;
      end else if (grant[1]) begin
         lastGrant <= 1'b1;
      end
   end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges two writeback requesters onto one register-file
// write port and tracks in-flight destinations to stall dependent decodes.
module wb_arbiter
   import wb_arbiter_pkg::*;
#(
   parameter int width     = 32,
   parameter int addrWidth = defaultAddrWidth
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 wbValid0,
   input  logic                 wbValid1,
   input  logic [addrWidth-1:0] wbAddr0,
   input  logic [addrWidth-1:0] wbAddr1,
   input  logic [width-1:0]     wbData0,
   input  logic [width-1:0]     wbData1,
   output logic                 wbReady0,
   output logic                 wbReady1,
   input  logic                 issueValid,
   input  logic [addrWidth-1:0] issueAddr,
   input  logic [addrWidth-1:0] addrA,
   input  logic [addrWidth-1:0] addrB,
   output logic                 stall,
   output logic                 regWriteEnable,
   output logic [addrWidth-1:0] addrD,
   output logic [width-1:0]     dataD
);

   localparam int numRegs = regCount(addrWidth);

   logic                 grant0;
   logic                 grant1;
   logic                 transfer;
   logic [addrWidth-1:0] grantAddr;
   logic [width-1:0]     grantData;
   logic [numRegs-1:0]   pending;
   logic [numRegs-1:0]   pendingNext;

   rr_arb2 arb (
      .clock  (clock),
      .reset  (reset),
      .valid0 (wbValid0),
      .valid1 (wbValid1),
      .grant0 (grant0),
      .grant1 (grant1)
   );

   assign wbReady0 = grant0;
   assign wbReady1 = grant1;

   // Select the winning requester's payload; grants are one-hot or idle.
   always_comb begin
      transfer  = grant0 | grant1;
      grantAddr = wbAddr0;
      grantData = wbData0;
      if (grant1) begin
         grantAddr = wbAddr1;
         grantData = wbData1;
      end
   end

   // Register write port trails the transfer by one cycle; register 0 is a
   // sink, so a writeback there is accepted but never reaches the file.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         regWriteEnable <= 1'b0;
         addrD          <= '0;
         dataD          <= '0;
      end else begin
         regWriteEnable <= transfer && (grantAddr != '0);
         if (transfer) begin
            addrD <= grantAddr;
            dataD <= grantData;
         end
      end
   end

   // Scoreboard update: the retiring write clears first and a same-cycle issue
   // to that register sets it again, since the newer producer is still owed.
   always_comb begin
      pendingNext = pending;
      if (regWriteEnable) begin
         pendingNext[addrD] = 1'b0;
      end
      if (issueValid && (issueAddr != '0)) begin
         pendingNext[issueAddr] = 1'b1;
      end
      pendingNext[0] = 1'b0;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         pending <= '0;
      end else begin
         pending <= pendingNext;
      end
   end

   // The file writes on the falling edge, so no forwarding is needed here.
   assign stall = pending[addrA] | pending[addrB];

endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: directed scenarios followed by randomized
// writeback/issue traffic checked against a rule-level reference model.
module tb_wb_arbiter;

   localparam int width     = 32;
   localparam int addrWidth = 5;

   typedef struct {
      logic [addrWidth-1:0] addr;
      logic [width-1:0]     data;
      int                   due;
   } wr_t;

   logic                 clock = 1'b0;
   logic                 reset = 1'b1;
   logic                 wbValid0 = 1'b0;
   logic                 wbValid1 = 1'b0;
   logic [addrWidth-1:0] wbAddr0 = '0;
   logic [addrWidth-1:0] wbAddr1 = '0;
   logic [width-1:0]     wbData0 = '0;
   logic [width-1:0]     wbData1 = '0;
   logic                 wbReady0;
   logic                 wbReady1;
   logic                 issueValid = 1'b0;
   logic [addrWidth-1:0] issueAddr = '0;
   logic [addrWidth-1:0] addrA = '0;
   logic [addrWidth-1:0] addrB = '0;
   logic                 stall;
   logic                 regWriteEnable;
   logic [addrWidth-1:0] addrD;
   logic [width-1:0]     dataD;

   wr_t                  expQ[$];
   int                   checks = 0;
   int                   errors = 0;
   int                   cyc = 0;
   bit                   pendModel[32];
   int                   lastWinner = 1;
   bit                   writeNow = 1'b0;
   logic [addrWidth-1:0] writeNowAddr = '0;
   bit                   rstReq = 1'b1;
   logic                 g0;
   logic                 g1;

   wb_arbiter #(.width(width), .addrWidth(addrWidth)) dut (
      .clock          (clock),
      .reset          (reset),
      .wbValid0       (wbValid0),
      .wbValid1       (wbValid1),
      .wbAddr0        (wbAddr0),
      .wbAddr1        (wbAddr1),
      .wbData0        (wbData0),
      .wbData1        (wbData1),
      .wbReady0       (wbReady0),
      .wbReady1       (wbReady1),
      .issueValid     (issueValid),
      .issueAddr      (issueAddr),
      .addrA          (addrA),
      .addrB          (addrB),
      .stall          (stall),
      .regWriteEnable (regWriteEnable),
      .addrD          (addrD),
      .dataD          (dataD)
   );

   always #5 clock = ~clock;

   task automatic checkVal(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s actual=%h expected=%h (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   // Write port monitor: each cycle either the oldest owed write is due and
   // must appear, or the port must be idle.
   initial begin
      wr_t w;
      forever begin
         @(posedge clock);
         cyc++;
         #1;
         if (reset) begin
            checkVal("rweDuringReset", regWriteEnable, 1'b0);
            writeNow = 1'b0;
         end else if (expQ.size() > 0 && expQ[0].due == cyc) begin
            w = expQ.pop_front();
            checkVal("rweDue", regWriteEnable, 1'b1);
            checkVal("addrD", addrD, w.addr);
            checkVal("dataD", dataD, w.data);
            writeNow     = 1'b1;
            writeNowAddr = w.addr;
         end else begin
            checkVal("rweIdle", regWriteEnable, 1'b0);
            writeNow = 1'b0;
         end
      end
   end

   // Compare combinational outputs against the rules, then advance the model
   // to the state it should hold after the coming clock edge.
   task automatic checkOutput(output logic e0, output logic e1);
      logic es;
      e0 = wbValid0 && (!wbValid1 || lastWinner == 1);
      e1 = wbValid1 && (!wbValid0 || lastWinner == 0);
      es = pendModel[addrA] | pendModel[addrB];
      checkVal("wbReady0", wbReady0, e0);
      checkVal("wbReady1", wbReady1, e1);
      checkVal("stall", stall, es);
      if (!reset) begin
         if (e0) begin
            if (wbAddr0 != 0) expQ.push_back('{wbAddr0, wbData0, cyc + 1});
            lastWinner = 0;
         end else if (e1) begin
            if (wbAddr1 != 0) expQ.push_back('{wbAddr1, wbData1, cyc + 1});
            lastWinner = 1;
         end
         if (writeNow) pendModel[writeNowAddr] = 1'b0;
         if (issueValid && issueAddr != 0) pendModel[issueAddr] = 1'b1;
      end
   endtask

   task automatic applyStimulus(
      input logic v0, input logic [addrWidth-1:0] a0, input logic [width-1:0] d0,
      input logic v1, input logic [addrWidth-1:0] a1, input logic [width-1:0] d1,
      input logic iv, input logic [addrWidth-1:0] ia,
      input logic [addrWidth-1:0] aA, input logic [addrWidth-1:0] aB,
      output logic gr0, output logic gr1);
      @(negedge clock);
      reset      = rstReq;
      wbValid0   = v0;
      wbAddr0    = a0;
      wbData0    = d0;
      wbValid1   = v1;
      wbAddr1    = a1;
      wbData1    = d1;
      issueValid = iv;
      issueAddr  = ia;
      addrA      = aA;
      addrB      = aB;
      #2;
      checkOutput(gr0, gr1);
   endtask

   task automatic idle(input logic [addrWidth-1:0] aA, input logic [addrWidth-1:0] aB);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, aA, aB, g0, g1);
   endtask

   // Reset arrives while one write is on the port and another is in flight.
   task automatic resetMidWrite();
      applyStimulus(1, 3, 32'h1111_0003, 0, 0, 0, 1, 12, 12, 0, g0, g1);
      applyStimulus(1, 4, 32'h1111_0004, 0, 0, 0, 0, 0, 12, 0, g0, g1);
      #1;
      rstReq = 1'b1;
      reset  = 1'b1;
      expQ.delete();
      foreach (pendModel[i]) pendModel[i] = 1'b0;
      lastWinner = 1;
      writeNow   = 1'b0;
      #1;
      checkVal("rweDroppedOnReset", regWriteEnable, 1'b0);
      checkVal("stallClearedOnReset", stall, 1'b0);
      checkVal("addrDOnReset", addrD, 0);
      checkVal("readyFollowsValidInReset", wbReady0, 1'b1);
      applyStimulus(1, 4, 32'h1111_0004, 1, 6, 32'h2222_0006, 1, 12, 12, 0, g0, g1);
      applyStimulus(0, 0, 0, 1, 6, 32'h2222_0006, 0, 0, 12, 0, g0, g1);
      rstReq = 1'b0;
      idle(12, 0);
      idle(12, 0);
   endtask

   initial begin
      logic                 r0v, r1v, iv;
      logic [addrWidth-1:0] r0a, r1a, ia, aA, aB;
      logic [width-1:0]     r0d, r1d;
      int                   drain;

      #3;
      checkVal("resetRwe", regWriteEnable, 1'b0);
      checkVal("resetAddrD", addrD, 0);
      checkVal("resetDataD", dataD, 0);
      checkVal("resetStall", stall, 1'b0);
      idle(0, 0);
      idle(0, 0);
      rstReq = 1'b0;
      idle(0, 0);

      // Contention straight after reset: grants 0,1,0,1, losers hold payload.
      applyStimulus(1, 1, 32'hA000_0000, 1, 2, 32'hB000_0000, 0, 0, 0, 0, g0, g1);
      checkVal("rrFirst0", {g0, g1}, 2'b10);
      applyStimulus(1, 3, 32'hA000_0001, 1, 2, 32'hB000_0000, 0, 0, 0, 0, g0, g1);
      checkVal("rrSecond1", {g0, g1}, 2'b01);
      applyStimulus(1, 3, 32'hA000_0001, 1, 4, 32'hB000_0001, 0, 0, 0, 0, g0, g1);
      checkVal("rrThird0", {g0, g1}, 2'b10);
      applyStimulus(1, 5, 32'hA000_0002, 1, 4, 32'hB000_0001, 0, 0, 0, 0, g0, g1);
      checkVal("rrFourth1", {g0, g1}, 2'b01);
      idle(0, 0);

      // Lone requester on address 5 is granted immediately.
      applyStimulus(1, 5, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, 0, 0, g0, g1);
      checkVal("loneGrant", {g0, g1}, 2'b10);
      idle(0, 0);
      idle(0, 0);

      // Issue to 7 stalls a reader of 7 until the cycle after its write.
      applyStimulus(0, 0, 0, 0, 0, 0, 1, 7, 7, 0, g0, g1);
      idle(7, 0);
      checkVal("stallOn7", stall, 1'b1);
      applyStimulus(0, 0, 0, 1, 7, 32'h0000_0777, 0, 0, 7, 0, g0, g1);
      idle(7, 0);
      idle(7, 0);
      checkVal("stallCleared7", stall, 1'b0);

      // Re-issue of 9 in the same cycle its write retires keeps it pending.
      applyStimulus(0, 0, 0, 0, 0, 0, 1, 9, 0, 9, g0, g1);
      applyStimulus(1, 9, 32'h0000_0999, 0, 0, 0, 0, 0, 0, 9, g0, g1);
      applyStimulus(0, 0, 0, 0, 0, 0, 1, 9, 0, 9, g0, g1);
      idle(0, 9);
      checkVal("stallHeld9", stall, 1'b1);
      applyStimulus(0, 0, 0, 1, 9, 32'h0000_9999, 0, 0, 0, 9, g0, g1);
      idle(0, 9);
      idle(0, 9);

      // Register 0 is never written and never pending.
      applyStimulus(1, 0, 32'h0BAD_0000, 0, 0, 0, 1, 0, 0, 0, g0, g1);
      idle(0, 0);
      checkVal("noWriteAddr0", regWriteEnable, 1'b0);
      idle(0, 0);

      resetMidWrite();

      r0v = 0; r1v = 0; r0a = 0; r1a = 0; r0d = 0; r1d = 0;
      for (int n = 0; n < 400; n++) begin
         if (!r0v && $urandom_range(0, 99) < 60) begin
            r0v = 1;
            r0a = addrWidth'($urandom_range(0, 7));
            r0d = $urandom;
         end
         if (!r1v && $urandom_range(0, 99) < 50) begin
            r1v = 1;
            r1a = addrWidth'($urandom_range(0, 31));
            r1d = $urandom;
         end
         iv = ($urandom_range(0, 3) == 0);
         ia = addrWidth'($urandom_range(0, 7));
         aA = addrWidth'($urandom_range(0, 7));
         aB = addrWidth'($urandom_range(0, 31));
         applyStimulus(r0v, r0a, r0d, r1v, r1a, r1d, iv, ia, aA, aB, g0, g1);
         if (g0) r0v = 0;
         if (g1) r1v = 0;
      end

      drain = 0;
      while (expQ.size() > 0 && drain < 5) begin
         idle(0, 0);
         drain++;
      end
      idle(0, 0);
      checkVal("drainQueueEmpty", expQ.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
